// File: rtl/exec_stage_unit_if.sv
// Handshake bundle between decode, the execute stage and the writeback consumer.
// The slave view belongs to the execute stage; the master view drives it.
interface exec_stage_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              reg_write;
    logic [2:0]        alu_op;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rd_addr;

    logic              wb_valid;
    logic              wb_ready;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_zero;
    logic              wb_carry;

    modport master (
        output in_valid, reg_write, alu_op, alu_src, mem_read, mem_write,
               branch, jump, rs1_data, rs2_data, imm, rd_addr, wb_ready,
        input  in_ready, wb_valid, wb_we, wb_addr, wb_data, wb_zero, wb_carry
    );

    modport slave (
        input  in_valid, reg_write, alu_op, alu_src, mem_read, mem_write,
               branch, jump, rs1_data, rs2_data, imm, rd_addr, wb_ready,
        output in_ready, wb_valid, wb_we, wb_addr, wb_data, wb_zero, wb_carry
    );
endinterface

// File: rtl/exec_stage_unit.sv
// Execute stage: operand-latch stage feeding a compute/writeback register, valid/ready
// on both sides with full back-pressure, plus a sticky illegal flag and retired-write counter.
module exec_stage_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    exec_stage_unit_if.slave bus,
    output logic             err_illegal,
    output logic [CNT_W-1:0] retired_cnt
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic              r_s1Valid;
    logic [DATA_W-1:0] r_s1OpA;
    logic [DATA_W-1:0] r_s1OpB;
    logic [2:0]        r_s1AluOp;
    logic [REG_AW-1:0] r_s1Rd;
    logic              r_s1WeReq;
    logic              r_s1Bad;

    logic              r_wbValid;
    logic              r_wbWe;
    logic [REG_AW-1:0] r_wbAddr;
    logic [DATA_W-1:0] r_wbData;
    logic              r_wbZero;
    logic              r_wbCarry;
    logic              r_errIllegal;
    logic [CNT_W-1:0]  r_retiredCnt;

    logic              w_s2CanLoad;
    logic              w_s1CanLoad;
    logic              w_accept;
    logic              w_inBad;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic              w_we;

    // The only combinational input-to-output path is wb_ready -> in_ready.
    assign w_s2CanLoad = ~r_wbValid | bus.wb_ready;
    assign w_s1CanLoad = ~r_s1Valid | w_s2CanLoad;
    assign w_accept    = bus.in_valid & w_s1CanLoad;
    assign w_inBad     = (bus.alu_op[2] & (bus.alu_op != OP_NOP)) | bus.mem_read
                       | bus.mem_write | bus.branch | bus.jump;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1OpA   <= '0;
            r_s1OpB   <= '0;
            r_s1AluOp <= OP_NOP;
            r_s1Rd    <= '0;
            r_s1WeReq <= 1'b0;
            r_s1Bad   <= 1'b0;
        end else if (w_s1CanLoad) begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1OpA   <= bus.rs1_data;
                r_s1OpB   <= bus.alu_src ? bus.imm : bus.rs2_data;
                r_s1AluOp <= bus.alu_op;
                r_s1Rd    <= bus.rd_addr;
                r_s1WeReq <= bus.reg_write;
                r_s1Bad   <= w_inBad;
            end
        end
    end

    // Bad entries and illegal opcodes fall through to a zero result with no carry.
    always_comb begin
        w_sum    = {1'b0, r_s1OpA} + {1'b0, r_s1OpB};
        w_diff   = {1'b0, r_s1OpA} - {1'b0, r_s1OpB};
        w_result = '0;
        w_carry  = 1'b0;
        if (!r_s1Bad) begin
            case (r_s1AluOp)
                OP_ADD: begin
                    w_result = w_sum[DATA_W-1:0];
                    w_carry  = w_sum[DATA_W];
                end
                OP_SUB: begin
                    w_result = w_diff[DATA_W-1:0];
                    w_carry  = w_diff[DATA_W];
                end
                OP_AND:  w_result = r_s1OpA & r_s1OpB;
                OP_OR:   w_result = r_s1OpA | r_s1OpB;
                default: w_result = '0;
            endcase
        end
        w_we = r_s1WeReq & ~r_s1Bad & (r_s1AluOp != OP_NOP) & (r_s1Rd != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbValid    <= 1'b0;
            r_wbWe       <= 1'b0;
            r_wbAddr     <= '0;
            r_wbData     <= '0;
            r_wbZero     <= 1'b0;
            r_wbCarry    <= 1'b0;
            r_errIllegal <= 1'b0;
        end else if (w_s2CanLoad) begin
            r_wbValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_wbWe    <= w_we;
                r_wbAddr  <= r_s1Rd;
                r_wbData  <= w_result;
                r_wbZero  <= (w_result == '0);
                r_wbCarry <= w_carry;
                if (r_s1Bad) begin
                    r_errIllegal <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retiredCnt <= '0;
        end else if (r_wbValid & bus.wb_ready & r_wbWe) begin
            r_retiredCnt <= r_retiredCnt + CNT_W'(1);
        end
    end

    assign bus.in_ready = w_s1CanLoad;
    assign bus.wb_valid = r_wbValid;
    assign bus.wb_we    = r_wbWe;
    assign bus.wb_addr  = r_wbAddr;
    assign bus.wb_data  = r_wbData;
    assign bus.wb_zero  = r_wbZero;
    assign bus.wb_carry = r_wbCarry;
    assign err_illegal  = r_errIllegal;
    assign retired_cnt  = r_retiredCnt;
endmodule

// File: tb/tb_exec_stage_unit.sv
// Directed bench for exec_stage_unit: reset, back-to-back ALU ops, back-pressure,
// illegal/unsupported ops, register-0/NOP suppression, counter wrap and mid-stream reset.
module tb_exec_stage_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       err_illegal;
    logic [3:0] retired_cnt;
    int         checks = 0;
    int         errors = 0;

    exec_stage_unit_if #(.DATA_W(32), .REG_AW(5)) bus();

    exec_stage_unit #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err_illegal(err_illegal),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.reg_write = 1'b0;
        bus.alu_op    = 3'b000;
        bus.alu_src   = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.branch    = 1'b0;
        bus.jump      = 1'b0;
        bus.rs1_data  = '0;
        bus.rs2_data  = '0;
        bus.imm       = '0;
        bus.rd_addr   = '0;
    endtask

    // unsup = {mem_read, mem_write, branch, jump}
    task automatic applyStimulus(input logic [2:0] op, input logic src, input logic rw,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic [4:0] rd,
                                 input logic [3:0] unsup);
        bus.in_valid  = 1'b1;
        bus.alu_op    = op;
        bus.alu_src   = src;
        bus.reg_write = rw;
        bus.rs1_data  = a;
        bus.rs2_data  = b;
        bus.imm       = im;
        bus.rd_addr   = rd;
        bus.mem_read  = unsup[3];
        bus.mem_write = unsup[2];
        bus.branch    = unsup[1];
        bus.jump      = unsup[0];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wb_ready = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_zero, bus.wb_carry} !== 40'h0) begin
            errors++;
            $display("[TB] FAIL reset_wb: got v=%b we=%b a=%h d=%h z=%b c=%b expected all 0",
                     bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_zero, bus.wb_carry);
        end
        checks++;
        if ({err_illegal, retired_cnt} !== 5'h0) begin
            errors++;
            $display("[TB] FAIL reset_dbg: got err=%b cnt=%0d expected 0/0", err_illegal, retired_cnt);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        bus.wb_ready = 1'b1;
        applyStimulus(3'b000, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h55, 32'h1, 5'd3, 4'b0000);
        step();
        applyStimulus(3'b001, 1'b0, 1'b1, 32'd5, 32'd7, 32'h100, 5'd4, 4'b0000);
        checks++;
        if (bus.wb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_latency: wb_valid got %b expected 0 one cycle after accept", bus.wb_valid);
        end
        step();
        idle();
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_zero, bus.wb_carry}
            !== {1'b1, 1'b1, 5'd3, 32'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL b2b_add: got v=%b we=%b a=%0d d=%h z=%b c=%b expected v=1 we=1 a=3 d=0 z=1 c=1",
                     bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_zero, bus.wb_carry);
        end
        step();
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_zero, bus.wb_carry}
            !== {1'b1, 1'b1, 5'd4, 32'hFFFF_FFFE, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL b2b_sub: got v=%b we=%b a=%0d d=%h z=%b c=%b expected v=1 we=1 a=4 d=fffffffe z=0 c=1",
                     bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_zero, bus.wb_carry);
        end
        checks++;
        if (retired_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL b2b_cnt1: got %0d expected 1", retired_cnt);
        end
        step();
        checks++;
        if ({bus.wb_valid, retired_cnt} !== {1'b0, 4'd2}) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got v=%b cnt=%0d expected v=0 cnt=2", bus.wb_valid, retired_cnt);
        end
    endtask

    task automatic test_backpressure();
        bus.wb_ready = 1'b0;
        applyStimulus(3'b011, 1'b0, 1'b1, 32'hF0, 32'h0F, 32'h0, 5'd5, 4'b0000);
        step();
        applyStimulus(3'b011, 1'b1, 1'b1, 32'h100, 32'hAA, 32'h1, 5'd6, 4'b0000);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_ready_s1only: got %b expected 1", bus.in_ready);
        end
        step();
        applyStimulus(3'b011, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 5'd7, 4'b0000);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_ready_full: got %b expected 0", bus.in_ready);
        end
        step();
        step();
        step();
        checks++;
        if ({bus.wb_valid, bus.wb_addr, bus.wb_data, bus.in_ready} !== {1'b1, 5'd5, 32'hFF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL bp_hold: got v=%b a=%0d d=%h rdy=%b expected v=1 a=5 d=ff rdy=0",
                     bus.wb_valid, bus.wb_addr, bus.wb_data, bus.in_ready);
        end
        bus.wb_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_ready_release: got %b expected 1", bus.in_ready);
        end
        step();
        idle();
        checks++;
        if ({bus.wb_valid, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd6, 32'h101}) begin
            errors++;
            $display("[TB] FAIL bp_second: got v=%b a=%0d d=%h expected v=1 a=6 d=101",
                     bus.wb_valid, bus.wb_addr, bus.wb_data);
        end
        step();
        checks++;
        if ({bus.wb_valid, bus.wb_addr, bus.wb_data, bus.wb_zero} !== {1'b1, 5'd7, 32'h0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL bp_third: got v=%b a=%0d d=%h z=%b expected v=1 a=7 d=0 z=1",
                     bus.wb_valid, bus.wb_addr, bus.wb_data, bus.wb_zero);
        end
        step();
        checks++;
        if ({bus.wb_valid, retired_cnt} !== {1'b0, 4'd5}) begin
            errors++;
            $display("[TB] FAIL bp_drain: got v=%b cnt=%0d expected v=0 cnt=5", bus.wb_valid, retired_cnt);
        end
    endtask

    task automatic test_reg0_nop();
        bus.wb_ready = 1'b1;
        applyStimulus(3'b000, 1'b0, 1'b1, 32'd4, 32'd4, 32'h0, 5'd0, 4'b0000);
        step();
        idle();
        step();
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data} !== {1'b1, 1'b0, 5'd0, 32'd8}) begin
            errors++;
            $display("[TB] FAIL reg0_write: got v=%b we=%b a=%0d d=%h expected v=1 we=0 a=0 d=8",
                     bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data);
        end
        step();
        checks++;
        if (retired_cnt !== 4'd5) begin
            errors++;
            $display("[TB] FAIL reg0_cnt: got %0d expected 5", retired_cnt);
        end
        applyStimulus(3'b111, 1'b0, 1'b1, 32'd9, 32'd9, 32'h0, 5'd2, 4'b0000);
        step();
        idle();
        step();
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_data, bus.wb_zero, bus.wb_carry, err_illegal}
            !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL nop: got v=%b we=%b d=%h z=%b c=%b err=%b expected v=1 we=0 d=0 z=1 c=0 err=0",
                     bus.wb_valid, bus.wb_we, bus.wb_data, bus.wb_zero, bus.wb_carry, err_illegal);
        end
        step();
        checks++;
        if (retired_cnt !== 4'd5) begin
            errors++;
            $display("[TB] FAIL nop_cnt: got %0d expected 5", retired_cnt);
        end
    endtask

    task automatic test_illegal();
        bus.wb_ready = 1'b1;
        applyStimulus(3'b101, 1'b0, 1'b1, 32'h12, 32'h34, 32'h0, 5'd7, 4'b0000);
        step();
        idle();
        checks++;
        if (err_illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_early: err got %b expected 0 before S2 load", err_illegal);
        end
        step();
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_zero, bus.wb_carry, err_illegal}
            !== {1'b1, 1'b0, 5'd7, 32'h0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL illegal_op: got v=%b we=%b a=%0d d=%h z=%b c=%b err=%b expected v=1 we=0 a=7 d=0 z=1 c=0 err=1",
                     bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_zero, bus.wb_carry, err_illegal);
        end
        step();
        applyStimulus(3'b000, 1'b0, 1'b1, 32'd2, 32'd3, 32'h0, 5'd8, 4'b0010);
        step();
        idle();
        step();
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_data, bus.wb_zero, err_illegal} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL illegal_branch: got v=%b we=%b d=%h z=%b err=%b expected v=1 we=0 d=0 z=1 err=1",
                     bus.wb_valid, bus.wb_we, bus.wb_data, bus.wb_zero, err_illegal);
        end
        step();
        applyStimulus(3'b000, 1'b0, 1'b1, 32'd10, 32'd20, 32'h0, 5'd9, 4'b0000);
        step();
        idle();
        step();
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_data, err_illegal} !== {1'b1, 1'b1, 32'd30, 1'b1}) begin
            errors++;
            $display("[TB] FAIL illegal_sticky: got v=%b we=%b d=%h err=%b expected v=1 we=1 d=1e err=1",
                     bus.wb_valid, bus.wb_we, bus.wb_data, err_illegal);
        end
        step();
        checks++;
        if (retired_cnt !== 4'd6) begin
            errors++;
            $display("[TB] FAIL illegal_cnt: got %0d expected 6", retired_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        rst = 1'b1;
        idle();
        bus.wb_ready = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(3'b000, 1'b0, 1'b1, 32'(i + 1), 32'h0, 32'h0, 5'd1, 4'b0000);
            step();
        end
        idle();
        step();
        checks++;
        if ({retired_cnt, bus.wb_valid, bus.wb_data, err_illegal} !== {4'd0, 1'b1, 32'd17, 1'b0}) begin
            errors++;
            $display("[TB] FAIL wrap_zero: got cnt=%0d v=%b d=%h err=%b expected cnt=0 v=1 d=11 err=0",
                     retired_cnt, bus.wb_valid, bus.wb_data, err_illegal);
        end
        step();
        checks++;
        if ({retired_cnt, bus.wb_valid} !== {4'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL wrap_one: got cnt=%0d v=%b expected cnt=1 v=0", retired_cnt, bus.wb_valid);
        end
    endtask

    task automatic test_reset_midstream();
        bus.wb_ready = 1'b0;
        applyStimulus(3'b000, 1'b0, 1'b1, 32'd1, 32'd1, 32'h0, 5'd2, 4'b0000);
        step();
        applyStimulus(3'b000, 1'b0, 1'b1, 32'd2, 32'd2, 32'h0, 5'd3, 4'b0000);
        step();
        idle();
        checks++;
        if ({bus.wb_valid, bus.in_ready, bus.wb_data} !== {1'b1, 1'b0, 32'd2}) begin
            errors++;
            $display("[TB] FAIL mid_full: got v=%b rdy=%b d=%h expected v=1 rdy=0 d=2",
                     bus.wb_valid, bus.in_ready, bus.wb_data);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_zero, bus.wb_carry, err_illegal, retired_cnt}
            !== 45'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got v=%b we=%b a=%0d d=%h z=%b c=%b err=%b cnt=%0d expected all 0",
                     bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_zero, bus.wb_carry,
                     err_illegal, retired_cnt);
        end
        rst = 1'b0;
        bus.wb_ready = 1'b1;
        step();
        step();
        checks++;
        if ({bus.wb_valid, bus.in_ready} !== {1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mid_after: got v=%b rdy=%b expected v=0 rdy=1", bus.wb_valid, bus.in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_reg0_nop();
        test_illegal();
        test_counter_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_stage_unit.md
Name: exec_stage_unit

Overview:
Execute stage that consumes the decoded control bundle (reg_write, alu_op, alu_src, mem_read, mem_write, branch, jump) together with operands, and produces a registered writeback transaction. It has a 2-stage pipeline: operand latch, then compute/output register. Both ends use valid/ready handshakes, with full back-pressure. It also keeps a sticky illegal-operation flag and a retired-write counter for debug.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, destination register index width
CNT_W, 16, retired-write counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  control bundle + operands valid
in_ready  out  1  stage can accept this cycle
reg_write  in  1  decoded register-write enable
alu_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 111 NOP; 100-110 illegal
alu_src  in  1  0: operand B = rs2_data, 1: operand B = imm
mem_read  in  1  unsupported by this stage
mem_write  in  1  unsupported by this stage
branch  in  1  unsupported by this stage
jump  in  1  unsupported by this stage
rs1_data  in  DATA_W  operand A
rs2_data  in  DATA_W  operand B (register)
imm  in  DATA_W  operand B (immediate)
rd_addr  in  REG_AW  destination register
wb_valid  out  1  writeback transaction valid
wb_ready  in  1  writeback consumer accepts
wb_we  out  1  register write enable
wb_addr  out  REG_AW  destination register
wb_data  out  DATA_W  result
wb_zero  out  1  result == 0
wb_carry  out  1  ADD carry-out / SUB borrow
err_illegal  out  1  sticky illegal/unsupported flag
retired_cnt  out  CNT_W  count of accepted writebacks with wb_we=1

Behaviour:
- Reset (async, rst=1): all pipeline valids clear. All outputs go to 0: wb_valid, wb_we, wb_addr, wb_data, wb_zero, wb_carry, err_illegal, retired_cnt. in_ready=1 while rst is deasserted and the pipe is empty. Reset mid-operation drops all in-flight transactions; nothing is emitted afterwards.
- Input accept when in_valid & in_ready.
  - S1 latches operand A and operand B (mux chosen by alu_src at accept time), alu_op, rd_addr, and we_req = reg_write.
  - S1 also latches bad = illegal alu_op | mem_read | mem_write | branch | jump.
- Stage advance: S2 (output reg) loads when S2 is empty or (wb_valid & wb_ready). S1 loads when S1 is empty or S1 moves to S2 in the same cycle.
  - in_ready = ~s1_valid | s2_can_load. It is combinational from wb_ready; no other combinational in->out path.
- Latency: accept at edge N, so wb_valid at edge N+2 when there is no stall. Throughput is 1 per cycle with wb_ready held high.
- Hold: while wb_valid & ~wb_ready, all wb_* outputs stay stable and S1 holds. in_ready=0 only when both stages are full and S2 is stalled.
- Compute (S2 load), all widths DATA_W, wrap modulo 2^DATA_W:
  - ADD: data=A+B, carry=carry-out.
  - SUB: data=A-B, carry=1 iff A<B unsigned.
  - AND/OR: carry=0.
  - NOP: data=0, carry=0, we=0.
- wb_we = we_req & ~bad & (alu_op != NOP) & (rd_addr != 0). Writes to register 0 are always suppressed; the transaction is still emitted.
- bad transaction: emitted with wb_we=0, wb_data=0, wb_zero=1, wb_carry=0. err_illegal sets on S2 load of a bad entry and stays 1 until reset.
- wb_zero = (wb_data == 0) for every emitted transaction.
- retired_cnt increments on wb_valid & wb_ready & wb_we. It wraps from 2^CNT_W-1 to 0 with no saturation.
- Input signals are don't-care while in_valid=0. A transaction is never duplicated or dropped across stalls.

Test Plan:
- Reset mid-stream: rst=1 while both stages are full -> all outputs 0 next cycle, no wb_valid after release, in_ready=1.
- Back-to-back ADD then SUB, wb_ready=1:
  - ADD rs1=0xFFFFFFFF, imm=1, alu_src=1, rd=3 -> after 2 cycles wb_data=0, wb_carry=1, wb_zero=1, wb_we=1, wb_addr=3.
  - Next cycle, SUB 5-7 -> wb_data=0xFFFFFFFE, wb_carry=1.
- Back-pressure: hold wb_ready=0 for 4 cycles while sending 3 ORs -> in_ready drops after 2 accepts, wb_* stable. On release, results come out in order, one per cycle, none lost.
- Illegal: alu_op=101 with reg_write=1, rd=7 -> wb_valid with wb_we=0, wb_data=0, err_illegal=1 and stays 1 through later legal ops. Same outcome for a legal ADD with branch=1.
- Register-0 and NOP: ADD to rd=0 -> wb_we=0, retired_cnt unchanged. alu_op=111 with reg_write=1 -> wb_we=0, wb_data=0, err_illegal stays 0.
- Counter wrap (CNT_W=4): 17 accepted writes to rd=1 -> retired_cnt reads 1.
